// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential multiply-and-convert block:
// FSM state encoding, BCD geometry and the double-dabble digit adjust.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    BCD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          BCD_DIGITS = 5;
  localparam int          BCD_W      = 4 * BCD_DIGITS;
  localparam logic [3:0]  BCD_ADJ_TH = 4'd5;

  // Add 3 to every digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (v[4*d +: 4] >= BCD_ADJ_TH) r[4*d +: 4] = v[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: load captures the binary value and
// clears the BCD register, each step does one adjust-and-shift. 'last' is
// high while the final step is being performed; bcd_next is the value the
// BCD register takes on the current step, so the result of the final step
// can be captured by the owner on the same edge.
module bin2bcd_seq
  import mul_seq_pkg::*;
#(
  parameter int BIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd_next,
  output logic             last
);

  localparam int CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0]       bin_q;
  logic [BCD_W-1:0]       bcd_q;
  logic [CNT_W-1:0]       cnt;
  logic [BIN_W-1:0]       bin_shift;
  logic [BCD_W+BIN_W-1:0] shifted;

  // One double-dabble step: adjust all digits, then shift BCD:binary left.
  always_comb begin
    shifted   = {bcd_adjust(bcd_q), bin_q} << 1;
    bcd_next  = shifted[BCD_W+BIN_W-1:BIN_W];
    bin_shift = shifted[BIN_W-1:0];
    last      = (cnt == CNT_W'(BIN_W - 1));
  end

  // Shift register and step counter; load takes priority over step.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt   <= '0;
    end else if (step) begin
      bin_q <= bin_shift;
      bcd_q <= bcd_next;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned multiplier followed by binary-to-BCD conversion.
// OP_W shift-add cycles, then 2*OP_W double-dabble cycles, then a one-cycle
// DONE pulse. Results are registered only on entry to DONE.
// Optional macro MUL_SEQ_ABORT_EN adds an 'abort' input that cancels an
// operation in MUL or BCD without touching the held results.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int OP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef MUL_SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  output logic              busy,
  output logic              done,
  output logic [2*OP_W-1:0] product,
  output logic [BCD_W-1:0]  bcd
);

  localparam int PROD_W = 2 * OP_W;
  localparam int MCNT_W = $clog2(OP_W);

  state_t              state, state_nxt;
  logic [PROD_W-1:0]   acc, acc_next, mcand;
  logic [OP_W-1:0]     mplier;
  logic [MCNT_W-1:0]   mul_cnt;
  logic                mul_last;
  logic                accept, conv_load, conv_step, capture, abort_req;
  logic [BCD_W-1:0]    conv_bcd_next;
  logic                conv_last;

`ifdef MUL_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign mul_last = (mul_cnt == MCNT_W'(OP_W - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode; abort outranks every other transition.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    conv_load = 1'b0;
    conv_step = 1'b0;
    capture   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (abort_req) begin
          state_nxt = IDLE;
        end else if (mul_last) begin
          conv_load = 1'b1;
          state_nxt = BCD;
        end
      end
      BCD: begin
        busy = 1'b1;
        if (abort_req) begin
          state_nxt = IDLE;
        end else begin
          conv_step = 1'b1;
          if (conv_last) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add multiplier datapath and the result registers seen outside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      mul_cnt <= '0;
      product <= '0;
      bcd     <= '0;
    end else begin
      if (accept) begin
        acc     <= '0;
        mcand   <= {{OP_W{1'b0}}, op_a};
        mplier  <= op_b;
        mul_cnt <= '0;
      end else if (state == MUL) begin
        acc     <= acc_next;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        mul_cnt <= mul_cnt + 1'b1;
      end
      if (capture) begin
        product <= acc;
        bcd     <= conv_bcd_next;
      end
    end
  end

  // The converter is loaded with the product of the final MUL step.
  bin2bcd_seq #(
    .BIN_W (PROD_W)
  ) u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .load     (conv_load),
    .step     (conv_step),
    .bin      (acc_next),
    .bcd_next (conv_bcd_next),
    .last     (conv_last)
  );

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl (OP_W = 8). Inputs change and outputs are
// sampled on the falling edge; expected values are hand-computed constants.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [19:0] bcd;

  int n_checks;
  int n_fail;

  // Results the DUT should currently be holding.
  logic [15:0] exp_prev_p;
  logic [19:0] exp_prev_bcd;

  mul_seq_ctrl #(
    .OP_W (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef MUL_SEQ_ABORT_EN
    .abort   (abort),
`endif
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .bcd     (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one operation starting in an IDLE cycle. With hold_start, start
  // stays high and op_a switches to held_a after the accept edge.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit hold_start, input logic [7:0] held_a,
                        input logic [15:0] exp_p, input logic [19:0] exp_bcd);
    int k;
    int busy_cnt;
    @(negedge clk);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle done"}, done, 0);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);                       // E0
    @(negedge clk);
    if (hold_start) op_a = held_a;
    else            start = 1'b0;
    k        = 0;
    busy_cnt = 0;
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      if (k == 12) begin
        check({tag, " hold product"}, product, exp_prev_p);
        check({tag, " hold bcd"}, bcd, exp_prev_bcd);
      end
      @(negedge clk);
      k++;
    end
    check({tag, " done edge"}, k, 24);
    check({tag, " busy cycles"}, busy_cnt, 24);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " product"}, product, exp_p);
    check({tag, " bcd"}, bcd, exp_bcd);
    exp_prev_p   = exp_p;
    exp_prev_bcd = exp_bcd;
  endtask

  initial begin
    int dn;
    n_checks = 0;
    n_fail   = 0;
    exp_prev_p   = '0;
    exp_prev_bcd = '0;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op_a  = '0;
    op_b  = '0;

    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset product", product, 0);
    check("reset bcd", bcd, 0);
    rst = 1'b0;

    run_op("12x10", 8'd12, 8'd10, 1'b0, 8'd0, 16'd120, 20'h00120);
    run_op("255x255", 8'd255, 8'd255, 1'b0, 8'd0, 16'd65025, 20'h65025);
    run_op("0x200", 8'd0, 8'd200, 1'b0, 8'd0, 16'd0, 20'h00000);
    run_op("7x9 held", 8'd7, 8'd9, 1'b1, 8'd3, 16'd63, 20'h00063);
    run_op("3x9 b2b", 8'd3, 8'd9, 1'b0, 8'd0, 16'd27, 20'h00027);

    // Reset during BCD, after E15.
    @(negedge clk);
    start = 1'b1;
    op_a  = 8'd12;
    op_b  = 8'd10;
    @(posedge clk);                       // E0
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(posedge clk);           // E15
    @(negedge clk);
    check("pre-rst busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid-rst busy", busy, 0);
    check("mid-rst product", product, 0);
    check("mid-rst bcd", bcd, 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("no done after rst", dn, 0);
    exp_prev_p   = '0;
    exp_prev_bcd = '0;
    run_op("99x11 post-rst", 8'd99, 8'd11, 1'b0, 8'd0, 16'd1089, 20'h01089);

`ifdef MUL_SEQ_ABORT_EN
    // Abort in MUL with start also high: back to IDLE, results kept.
    @(negedge clk);
    start = 1'b1;
    op_a  = 8'd50;
    op_b  = 8'd50;
    @(posedge clk);                       // E0
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);            // E4
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);                       // E5
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort busy", busy, 0);
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort no done", dn, 0);
    check("abort product", product, exp_prev_p);
    check("abort bcd", bcd, exp_prev_bcd);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter: OP_W, 8, operand width in bits; legal range 4..8; product width 2*OP_W; BCD output fixed at 5 digits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request one multiply-and-convert operation.
REQ-005 SHALL have port: op_a  input  OP_W  multiplicand, sampled on the start-accept edge.
REQ-006 SHALL have port: op_b  input  OP_W  multiplier, sampled on the start-accept edge.
REQ-007 SHALL have port: busy  output  1  high in states MUL and BCD.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; high only in state DONE.
REQ-009 SHALL have port: product  output  2*OP_W  unsigned op_a*op_b.
REQ-010 SHALL have port: bcd  output  20  5-digit packed BCD of product; digit 0 in [3:0].

Function
REQ-011 SHALL implement FSM states IDLE, MUL, BCD, DONE.
REQ-012 SHALL accept start only in IDLE; the accept edge E0 captures op_a/op_b and moves to MUL.
REQ-013 SHALL ignore start in MUL, BCD and DONE; no queuing; operands are not re-sampled.
REQ-014 MUL SHALL perform one shift-add step per cycle, LSB of multiplier first, for exactly OP_W cycles; accumulator is 2*OP_W bits wide and never overflows.
REQ-015 BCD SHALL perform one double-dabble step per cycle for exactly 2*OP_W cycles; every digit >=5 gets +3 before each shift, including the top digit.
REQ-016 SHALL enter DONE after edge E(3*OP_W) and return to IDLE on the following edge; with OP_W=8, done is high in the cycle after E24.
REQ-017 product and bcd SHALL update only on the edge entering DONE and hold until the next DONE; no intermediate values are visible.
REQ-018 SHALL let start in the IDLE cycle after DONE be accepted, giving back-to-back operation every 3*OP_W+2 cycles.
REQ-019 Zero operands SHALL take full latency and yield product=0, bcd=0.

Reset
REQ-020 rst SHALL force IDLE immediately, from any state including mid-MUL/mid-BCD, discarding the operation in progress.
REQ-021 Reset values SHALL be: busy=0, done=0, product=0, bcd=0, internal accumulators/counters=0.
REQ-022 The first start accept SHALL occur on the first rising edge with rst low and start high.

Configuration
REQ-023 Macro MUL_SEQ_ABORT_EN SHALL add input abort (1 bit); when defined, abort high in MUL or BCD returns to IDLE on the next edge, without DONE and with product/bcd unchanged; abort has no effect in IDLE/DONE; abort wins over start in the same cycle.
REQ-024 Without MUL_SEQ_ABORT_EN, the abort port SHALL not exist and operations always run to completion unless rst is asserted.

Structure
REQ-025 Package mul_seq_pkg SHALL hold the state enum typedef, BCD_DIGITS=5, BCD_W=20 and the +3 adjust threshold constant 5.
REQ-026 SHALL instantiate one sub-module bin2bcd_seq, the iterative double-dabble converter with load/step/count; the FSM drives its load and step controls.

Verification
REQ-027 op_a=12, op_b=10, start pulse at E0 -> done high after E24, product=120, bcd=20'h00120, busy high for exactly 24 cycles.
REQ-028 op_a=255, op_b=255 -> product=65025, bcd=20'h65025.
REQ-029 op_a=0, op_b=200 -> product=0, bcd=0, done still after E24.
REQ-030 start at E0 with 7*9, start held high with op_a=3 through E24 -> result 63/bcd 20'h00063; the IDLE cycle after DONE accepts 3*op_b.
REQ-031 rst asserted for one cycle during BCD (E15) -> busy=0, outputs zeroed, no done pulse; the next start produces a correct full-latency result.
REQ-032 With MUL_SEQ_ABORT_EN: abort at E5 with start also high -> IDLE at E6, no done, prior product/bcd retained.
